// File: rtl/uart_pkg.sv
// uart_pkg: receiver state encoding and counter sizing shared by the UART blocks
package uart_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} rx_state_t;

   // bits needed to hold a down-counter loaded with at most n-1
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_rx.sv
// uart_rx: synchronizes the serial line and deserializes 8N1-style frames
module uart_rx import uart_pkg::*; #(
   parameter int WIDTH         = 8,
   parameter int DIVISOR       = 100,
   parameter int LITTLE_ENDIAN = 0
)(
   input  logic             clk,
   input  logic             i_reset_n,
   input  logic             i_rx_enable,
   input  logic             i_rx,
   output logic [WIDTH-1:0] o_data,
   output logic             o_dv,
   output logic             o_frame_err,
   output logic             o_busy
);

   localparam int CW = cnt_width(DIVISOR);
   localparam int IW = cnt_width(WIDTH);

   rx_state_t        r_state, w_state_nxt;
   logic [1:0]       r_sync;
   logic             r_rxs_d;
   logic [CW-1:0]    r_cnt, w_cnt_nxt;
   logic [IW-1:0]    r_idx, w_idx_nxt;
   logic [WIDTH-1:0] r_shift, w_shift_nxt;
   logic             r_dv, w_dv_nxt, r_ferr, w_ferr_nxt;
   logic             w_rxs, w_exp;

   assign w_rxs       = r_sync[1];
   assign w_exp       = (r_cnt == '0);
   assign o_data      = r_shift;
   assign o_dv        = r_dv;
   assign o_frame_err = r_ferr;
   assign o_busy      = (r_state != IDLE);

   // line synchronizer, previous-sample register for start-edge detection, and FSM state
   always_ff @(posedge clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_sync  <= 2'b11;
         r_rxs_d <= 1'b1;
         r_state <= IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_shift <= '0;
         r_dv    <= 1'b0;
         r_ferr  <= 1'b0;
      end else begin
         r_sync  <= {r_sync[0], i_rx};
         r_rxs_d <= w_rxs;
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
         r_shift <= w_shift_nxt;
         r_dv    <= w_dv_nxt;
         r_ferr  <= w_ferr_nxt;
      end
   end

   // next state, bit timing and shift logic; enable low overrides everything back to IDLE
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = w_exp ? r_cnt : r_cnt - CW'(1);
      w_idx_nxt   = r_idx;
      w_shift_nxt = r_shift;
      w_dv_nxt    = 1'b0;
      w_ferr_nxt  = 1'b0;
      case (r_state)
         IDLE: if (r_rxs_d && !w_rxs) begin
            w_state_nxt = START;
            w_cnt_nxt   = CW'(DIVISOR/2 - 1);
         end
         START: if (w_exp) begin
            w_state_nxt = w_rxs ? IDLE : DATA;
            w_cnt_nxt   = CW'(DIVISOR - 1);
            w_idx_nxt   = '0;
         end
         DATA: if (w_exp) begin
            w_cnt_nxt   = CW'(DIVISOR - 1);
            w_shift_nxt = (LITTLE_ENDIAN != 0) ? {w_rxs, r_shift[WIDTH-1:1]}
                                               : {r_shift[WIDTH-2:0], w_rxs};
            w_idx_nxt   = r_idx + IW'(1);
            w_state_nxt = (r_idx == IW'(WIDTH - 1)) ? STOP : DATA;
         end
         STOP: if (w_exp) begin
            w_dv_nxt    = w_rxs;
            w_ferr_nxt  = !w_rxs;
            w_state_nxt = w_rxs ? IDLE : WAIT_IDLE;
         end
         WAIT_IDLE: w_state_nxt = w_rxs ? IDLE : WAIT_IDLE;
         default: w_state_nxt = IDLE;
      endcase
      if (!i_rx_enable) begin
         w_state_nxt = IDLE;
         w_dv_nxt    = 1'b0;
         w_ferr_nxt  = 1'b0;
      end
   end

endmodule

// File: rtl/fifo_uart_rx.sv
// fifo_uart_rx: UART receiver feeding a word FIFO with registered status flags
module fifo_uart_rx import uart_pkg::*; #(
   parameter int WIDTH         = 8,
   parameter int DEPTH         = 128,
   parameter int DIVISOR       = 100,
   parameter int LEVEL         = 16,
   parameter int LITTLE_ENDIAN = 0
)(
   input  logic             clk,
   input  logic             i_reset_n,
   input  logic             i_rx_enable,
   input  logic             i_fifo_enable,
   input  logic             i_rx,
   input  logic             i_r_en,
   output logic [WIDTH-1:0] o_r_data,
   output logic             o_full,
   output logic             o_afull,
   output logic             o_empty,
   output logic             o_aempty,
   output logic             o_overflow,
   output logic             o_frame_err,
   output logic             o_busy
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_data, w_rx_data;
   logic [AW-1:0]    r_wptr, r_rptr;
   logic [AW:0]      r_count, w_count_nxt;
   logic             r_full, r_afull, r_empty, r_aempty, r_ovf;
   logic             w_dv, w_wr, w_rd;

   uart_rx #(.WIDTH(WIDTH), .DIVISOR(DIVISOR), .LITTLE_ENDIAN(LITTLE_ENDIAN)) u_rx (
      .clk         (clk),
      .i_reset_n   (i_reset_n),
      .i_rx_enable (i_rx_enable),
      .i_rx        (i_rx),
      .o_data      (w_rx_data),
      .o_dv        (w_dv),
      .o_frame_err (o_frame_err),
      .o_busy      (o_busy)
   );

   // a read frees a slot in the same cycle, so a full FIFO still accepts a word alongside a read
   assign w_rd        = i_r_en && !r_empty;
   assign w_wr        = w_dv && i_fifo_enable && (!r_full || i_r_en);
   assign w_count_nxt = r_count + {{AW{1'b0}}, w_wr} - {{AW{1'b0}}, w_rd};

   assign o_r_data   = r_data;
   assign o_full     = r_full;
   assign o_afull    = r_afull;
   assign o_empty    = r_empty;
   assign o_aempty   = r_aempty;
   assign o_overflow = r_ovf;

   // storage array needs no reset; validity is tracked by the pointers
   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wptr] <= w_rx_data;
   end

   // pointers, count, read data and flags registered from the next count
   always_ff @(posedge clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_count  <= '0;
         r_data   <= '0;
         r_full   <= 1'b0;
         r_afull  <= 1'b0;
         r_empty  <= 1'b1;
         r_aempty <= 1'b1;
         r_ovf    <= 1'b0;
      end else begin
         if (w_wr) r_wptr <= r_wptr + AW'(1);
         if (w_rd) begin
            r_rptr <= r_rptr + AW'(1);
            r_data <= r_mem[r_rptr];
         end
         r_count  <= w_count_nxt;
         r_full   <= (w_count_nxt == (AW+1)'(DEPTH));
         r_afull  <= (w_count_nxt >= (AW+1)'(DEPTH - LEVEL));
         r_empty  <= (w_count_nxt == '0);
         r_aempty <= (w_count_nxt <= (AW+1)'(LEVEL));
         r_ovf    <= w_dv && i_fifo_enable && r_full && !i_r_en;
      end
   end

endmodule

// File: doc/fifo_uart_rx.md
# fifo_uart_rx

Serial receive path for the register test design and the receive-side counterpart of the FIFO-fed UART transmitter. Samples an asynchronous serial line, deserializes 8N1 frames, and pushes each good word into an internal FIFO that the host logic reads at its own pace. Flags the same full/almost-full/empty/almost-empty status as the transmit side, and adds overflow and framing-error pulses.

## Interface
- WIDTH, 8: data bits per frame.
- DEPTH, 128: FIFO words, power of two.
- DIVISOR, 100: clk cycles per bit, ≥ 8.
- LEVEL, 16: almost-full/almost-empty threshold.
- LITTLE_ENDIAN, 0: 0 = MSB first on the line, 1 = LSB first. Must match the transmitter.

Ports:
- clk  in  1  sole clock. One clock; reset is asynchronous and active-low.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_rx_enable  in  1  receiver enable. Low holds the FSM in IDLE.
- i_fifo_enable  in  1  write gate. Low discards received words.
- i_rx  in  1  serial line, asynchronous, idle high.
- i_r_en  in  1  read strobe.
- o_r_data  out  WIDTH  read data.
- o_full / o_afull / o_empty / o_aempty  out  1  FIFO status.
- o_overflow  out  1  one-cycle pulse: good word dropped because the FIFO was full.
- o_frame_err  out  1  one-cycle pulse: stop bit sampled low.
- o_busy  out  1  high when the FSM is not in IDLE.

## Operation
- i_rx passes through a 2-flop synchronizer; its flops reset to 1. The FSM uses the synchronized value (rxs).
- FSM states are IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: a falling edge of rxs with i_rx_enable high loads bit counter = DIVISOR/2−1 and moves to START.
  - START: when the counter expires, rxs=0 moves to DATA; rxs=1 (glitch) returns to IDLE.
  - DATA: reloads DIVISOR−1 and samples one bit on each expiry. Bits fill from the MSB (LITTLE_ENDIAN=0) or the LSB (1). After WIDTH bits, moves to STOP.
  - STOP: on expiry, rxs=1 raises a write request for the shift register and moves to IDLE. rxs=0 pulses o_frame_err, drops the word, and moves to WAIT_IDLE.
  - WAIT_IDLE: moves to IDLE when rxs=1 (break handling).
- i_rx_enable low in any state forces IDLE on the next edge. A partial frame is discarded without any flag.
- A write request is accepted when i_fifo_enable=1 and (!full or i_r_en). Full with i_fifo_enable=1 and no read pulses o_overflow; FIFO contents are unchanged. i_fifo_enable=0 drops the word silently.
- Read: when i_r_en and !empty, o_r_data takes the head word on the next edge and the pointer advances. Reading while empty is ignored and o_r_data holds.
- Simultaneous read and write leave the count unchanged. Pointers are log2(DEPTH) bits and wrap naturally. The count is log2(DEPTH)+1 bits.
- Flag definitions:
  - o_full: count == DEPTH.
  - o_afull: count ≥ DEPTH−LEVEL.
  - o_empty: count == 0.
  - o_aempty: count ≤ LEVEL.

## Timing
- Reset values: o_r_data=0, o_empty=1, o_aempty=1, o_full=0, o_afull=0, o_overflow=0, o_frame_err=0, o_busy=0. The FSM resets to IDLE and the pointers and count to 0.
- Reset asserted mid-frame clears everything immediately. Reception restarts on the first falling edge after release.
- Let T0 be the clk edge where the i_rx fall is first captured.
  - Data bit k is sampled at T0 + 2 + DIVISOR/2 + (k+1)·DIVISOR.
  - The stop bit is sampled at T0 + 2 + DIVISOR/2 + (WIDTH+1)·DIVISOR.
- The write lands one cycle after the stop sample. Status flags are registered and update on that same edge, so o_empty falls 1 cycle after the stop sample.
- Read latency is 1 cycle from i_r_en to o_r_data. Flags update on the read edge.
- o_overflow and o_frame_err assert on the write-attempt edge and the stop-sample edge respectively.
- Back-to-back frames are supported. A start edge in the first cycle of IDLE is detected.

## Structure
- Package uart_pkg holds rx_state_t (enum IDLE/START/DATA/STOP/WAIT_IDLE) and a localparam function computing the counter width from DIVISOR. The transmitter shares this package.
- Sub-module uart_rx holds the synchronizer, FSM, bit counter and shift register. It outputs o_data, o_dv (1 cycle), o_frame_err and o_busy.
- The top level holds the FIFO storage, pointers, count, flags and overflow logic. The FIFO is inline because it needs an async active-low reset.

## Test plan
- Reset, then one frame 0xA5 with DIVISOR=16 and LITTLE_ENDIAN=0.
  - Required: o_empty falls exactly 1 cycle after the stop sample.
  - Required: i_r_en returns 0xA5 on the next cycle and o_empty rises again.
- LITTLE_ENDIAN=1, line bits (first to last) 1,0,0,0,0,0,0,0.
  - Required: reads 0x01.
  - With LITTLE_ENDIAN=0 the same bits read 0x80.
- Stop bit driven low with data 0x3C.
  - Required: o_frame_err pulses once and the FIFO stays empty.
  - Required: the FSM stays in WAIT_IDLE until the line goes high, then receives the next frame 0x55 correctly.
- A 3-cycle low glitch on idle i_rx.
  - Required: returns to IDLE, no write, no flag.
- Send DEPTH+1 frames (0..128) with no reads.
  - Required: o_afull asserts at count 112 and o_full at 128.
  - Required: the last frame pulses o_overflow.
  - Required: 128 reads return 0..127, and o_aempty re-asserts at count 16.
- Mid-frame events.
  - Deassert i_rx_enable mid-frame: no write, o_busy=0 next cycle.
  - Assert i_reset_n=0 mid-frame with 5 words stored: all outputs take their reset values asynchronously and the count is 0.
